// File: rtl/param_sync_ram.sv
// Parametrised single-clock RAM with a post-reset init sweep, ready handshake and 2-cycle write-first read.
// Optional parity per word is enabled by defining RAM_PARITY_EN.
module param_sync_ram #(
    parameter int unsigned       DATA_W   = 3,
    parameter int unsigned       ADDR_W   = 5,
    parameter int unsigned       DEPTH    = 2 ** ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
`ifdef RAM_PARITY_EN
    input  logic              err_inject,
    output logic              rd_perr,
`endif
    output logic              ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);

`ifdef RAM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif
    localparam int unsigned CMP_W = ADDR_W + 1;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] init_cnt;
    logic [MEM_W-1:0]  mem [DEPTH];

    logic [MEM_W-1:0]  init_word;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              rd_hit;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [MEM_W-1:0]  wr_word_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;

    // Stored word: data plus (optionally) an even-parity bit, invertible for error injection
`ifdef RAM_PARITY_EN
    assign init_word = {^INIT_VAL, INIT_VAL};
    assign wr_word   = {(^wr_data) ^ err_inject, wr_data};
`else
    assign init_word = INIT_VAL;
    assign wr_word   = wr_data;
`endif

    assign ready = (state_q == ST_READY);

    // State register and sweep counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                init_cnt <= init_cnt + ADDR_W'(1);
            end
        end
    end

    // Next-state: leave INIT once the last word has been written
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (init_cnt == ADDR_W'(DEPTH - 1)) state_d = ST_READY;
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    assign wr_in_range = ({1'b0, wr_addr_q} < CMP_W'(DEPTH));
    assign rd_in_range = ({1'b0, rd_addr_q} < CMP_W'(DEPTH));
    assign rd_hit      = wr_en_q && (wr_addr_q == rd_addr_q);

    // Write-first: a same-cycle write to the read address is forwarded
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = rd_hit ? wr_word_q : mem[rd_addr_q];
        end
    end

    // Array writes; in-flight writes are discarded while reset is asserted
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_INIT) begin
                mem[init_cnt] <= init_word;
            end else if (wr_en_q && wr_in_range) begin
                mem[wr_addr_q] <= wr_word_q;
            end
        end
    end

    // Request capture stage and registered read result
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_word_q <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
`ifdef RAM_PARITY_EN
            rd_perr   <= 1'b0;
`endif
        end else begin
            wr_en_q   <= wr_en & ready;
            wr_addr_q <= wr_addr;
            wr_word_q <= wr_word;
            rd_en_q   <= rd_en & ready;
            rd_addr_q <= rd_addr;
            rd_valid  <= rd_en_q;
            if (rd_en_q) begin
                rd_data <= rd_word[DATA_W-1:0];
`ifdef RAM_PARITY_EN
                rd_perr <= ^rd_word;
`endif
            end
        end
    end

endmodule

// File: tb/tb_param_sync_ram.sv
// Directed self-checking bench for param_sync_ram: a default 32x3 instance and a 24-deep instance
// with a non-zero init value sharing the same stimulus.
module tb_param_sync_ram;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [2:0] wr_data;
    logic       rd_en;
    logic [4:0] rd_addr;
    logic       err_inject;
    logic       ready, rd_valid;
    logic [2:0] rd_data;
    logic       ready2, rd_valid2;
    logic [2:0] rd_data2;
`ifdef RAM_PARITY_EN
    logic       rd_perr, rd_perr2;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] model [32];

    always #5 clk = ~clk;

    param_sync_ram #(.DATA_W(3), .ADDR_W(5), .DEPTH(32), .INIT_VAL(3'b000)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef RAM_PARITY_EN
        .err_inject(err_inject), .rd_perr(rd_perr),
`endif
        .ready(ready), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    param_sync_ram #(.DATA_W(3), .ADDR_W(5), .DEPTH(24), .INIT_VAL(3'b011)) dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef RAM_PARITY_EN
        .err_inject(err_inject), .rd_perr(rd_perr2),
`endif
        .ready(ready2), .rd_valid(rd_valid2), .rd_data(rd_data2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs until both instances are ready; drops any pending request as soon as dut becomes ready
    task automatic wait_ready(output int n1, output int n2, output int vcnt);
        n1 = 0; n2 = 0; vcnt = 0;
        for (int c = 1; c <= 200; c++) begin
            tick;
            if (rd_valid) vcnt++;
            if (ready2 && n2 == 0) n2 = c;
            if (ready && n1 == 0) begin
                n1 = c;
                rd_en = 1'b0;
                wr_en = 1'b0;
            end
            if (n1 != 0 && n2 != 0) break;
        end
    endtask

    task automatic write1(input logic [4:0] a, input logic [2:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic read1(input logic [4:0] a, output logic [3:0] r1, output logic [3:0] r2);
        rd_en = 1'b1; rd_addr = a;
        tick;
        rd_en = 1'b0;
        tick;
        r1 = {rd_valid, rd_data};
        r2 = {rd_valid2, rd_data2};
    endtask

    task automatic test_reset;
        int n1, n2, vc;
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_inject = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        tick; tick;
        reset = 1'b0;
        n_cmp++;
        if ({ready, rd_valid, rd_data} !== 5'b0) begin
            n_bad++; $display("FAIL reset_outputs: got %b expected 00000", {ready, rd_valid, rd_data});
        end
        wait_ready(n1, n2, vc);
        n_cmp++;
        if (n1 != 32) begin n_bad++; $display("FAIL sweep_len_32: got %0d expected 32", n1); end
        n_cmp++;
        if (n2 != 24) begin n_bad++; $display("FAIL sweep_len_24: got %0d expected 24", n2); end
        for (int i = 0; i < 32; i++) model[i] = 3'b000;
    endtask

    task automatic test_init_reads;
        for (int i = 0; i <= 33; i++) begin
            rd_en = (i < 32); rd_addr = 5'(i);
            tick;
            n_cmp++;
            if (i == 0 || i == 33) begin
                if (rd_valid !== 1'b0) begin
                    n_bad++; $display("FAIL init_read_idle[%0d]: got valid %b expected 0", i, rd_valid);
                end
            end else if ({rd_valid, rd_data} !== {1'b1, model[i-1]}) begin
                n_bad++;
                $display("FAIL init_read[%0d]: got %b expected %b", i - 1, {rd_valid, rd_data}, {1'b1, model[i-1]});
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_depth_boundary;
        logic [3:0] r1, r2;
        read1(5'd23, r1, r2);
        n_cmp++;
        if (r2 !== 4'b1011) begin n_bad++; $display("FAIL d24_init_23: got %b expected 1011", r2); end
        read1(5'd24, r1, r2);
        n_cmp++;
        if (r2 !== 4'b1000) begin n_bad++; $display("FAIL d24_oor_24: got %b expected 1000", r2); end
        write1(5'd24, 3'b101); model[24] = 3'b101;
        write1(5'd23, 3'b001); model[23] = 3'b001;
        read1(5'd24, r1, r2);
        n_cmp++;
        if (r2 !== 4'b1000) begin n_bad++; $display("FAIL d24_oor_write_dropped: got %b expected 1000", r2); end
        n_cmp++;
        if (r1 !== 4'b1101) begin n_bad++; $display("FAIL d32_write_24: got %b expected 1101", r1); end
        read1(5'd23, r1, r2);
        n_cmp++;
        if (r2 !== 4'b1001) begin n_bad++; $display("FAIL d24_last_word: got %b expected 1001", r2); end
        read1(5'd31, r1, r2);
        n_cmp++;
        if (r2 !== 4'b1000) begin n_bad++; $display("FAIL d24_oor_31: got %b expected 1000", r2); end
    endtask

    task automatic test_write_read;
        write1(5'd5, 3'b101); model[5] = 3'b101;
        tick;
        rd_en = 1'b1; rd_addr = 5'd5;
        tick;
        rd_en = 1'b0;
        n_cmp++;
        if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL wr_rd_early_valid: got %b expected 0", rd_valid); end
        tick;
        n_cmp++;
        if ({rd_valid, rd_data} !== 4'b1101) begin
            n_bad++; $display("FAIL wr_rd_data: got %b expected 1101", {rd_valid, rd_data});
        end
        tick;
        n_cmp++;
        if ({rd_valid, rd_data} !== 4'b0101) begin
            n_bad++; $display("FAIL wr_rd_hold: got %b expected 0101", {rd_valid, rd_data});
        end
    endtask

    task automatic test_bypass;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 3'b110;
        rd_en = 1'b1; rd_addr = 5'd7;
        tick;
        wr_en = 1'b0; rd_en = 1'b0;
        tick;
        model[7] = 3'b110;
        n_cmp++;
        if ({rd_valid, rd_data} !== 4'b1110) begin
            n_bad++; $display("FAIL bypass_same_cycle: got %b expected 1110", {rd_valid, rd_data});
        end
    endtask

    task automatic test_write_next_read;
        write1(5'd3, 3'b011); model[3] = 3'b011;
        rd_en = 1'b1; rd_addr = 5'd3;
        tick;
        rd_en = 1'b0;
        tick;
        n_cmp++;
        if ({rd_valid, rd_data} !== 4'b1011) begin
            n_bad++; $display("FAIL write_then_read_next: got %b expected 1011", {rd_valid, rd_data});
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] e2;
        for (int i = 0; i < 32; i++) begin
            write1(5'(i), 3'(i * 5 + 3));
            model[i] = 3'(i * 5 + 3);
        end
        for (int i = 0; i <= 33; i++) begin
            rd_en = (i < 32); rd_addr = 5'(i);
            tick;
            if (i >= 1 && i <= 32) begin
                e2 = (i - 1 < 24) ? model[i-1] : 3'b000;
                n_cmp++;
                if ({rd_valid, rd_data} !== {1'b1, model[i-1]}) begin
                    n_bad++;
                    $display("FAIL b2b_read[%0d]: got %b expected %b", i - 1, {rd_valid, rd_data}, {1'b1, model[i-1]});
                end
                n_cmp++;
                if ({rd_valid2, rd_data2} !== {1'b1, e2}) begin
                    n_bad++;
                    $display("FAIL b2b_read_d24[%0d]: got %b expected %b", i - 1, {rd_valid2, rd_data2}, {1'b1, e2});
                end
            end
        end
        rd_en = 1'b0;
    endtask

`ifdef RAM_PARITY_EN
    task automatic test_parity;
        logic [3:0] r1, r2;
        err_inject = 1'b1;
        write1(5'd9, 3'b010);
        err_inject = 1'b0;
        read1(5'd9, r1, r2);
        n_cmp++;
        if ({rd_perr, r1} !== 5'b11010) begin
            n_bad++; $display("FAIL parity_injected: got %b expected 11010", {rd_perr, r1});
        end
        write1(5'd9, 3'b010);
        read1(5'd9, r1, r2);
        n_cmp++;
        if ({rd_perr, r1} !== 5'b01010) begin
            n_bad++; $display("FAIL parity_clean: got %b expected 01010", {rd_perr, r1});
        end
        model[9] = 3'b010;
    endtask
`endif

    task automatic test_reset_midflight;
        int n1, n2, vc;
        logic [3:0] r1, r2;
        write1(5'd5, 3'b101);
        rd_en = 1'b1; rd_addr = 5'd5;
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 3'b111;
        tick;
        rd_en = 1'b0; wr_en = 1'b0; reset = 1'b1;
        tick;
        n_cmp++;
        if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL midflight_valid: got %b expected 0", rd_valid); end
        reset = 1'b0;
        rd_en = 1'b1; rd_addr = 5'd5;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 3'b111;
        wait_ready(n1, n2, vc);
        n_cmp++;
        if (n1 != 32) begin n_bad++; $display("FAIL resweep_len: got %0d expected 32", n1); end
        n_cmp++;
        if (vc != 0) begin n_bad++; $display("FAIL sweep_valid_pulses: got %0d expected 0", vc); end
        tick; tick;
        n_cmp++;
        if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL dropped_request: got %b expected 0", rd_valid); end
        read1(5'd5, r1, r2);
        n_cmp++;
        if (r1 !== 4'b1000) begin n_bad++; $display("FAIL reinit_addr5: got %b expected 1000", r1); end
        read1(5'd6, r1, r2);
        n_cmp++;
        if (r1 !== 4'b1000) begin n_bad++; $display("FAIL reinit_addr6: got %b expected 1000", r1); end
    endtask

    initial begin
        test_reset;
        test_init_reads;
        test_depth_boundary;
        test_write_read;
        test_bypass;
        test_write_next_read;
        test_back_to_back;
`ifdef RAM_PARITY_EN
        test_parity;
`endif
        test_reset_midflight;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
